// File: rtl/alu_mc_pkg.sv
// Shared opcode and FSM state constants for the multicycle ALU and its control unit.
package alu_mc_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_LESS = 4'b0111;
    localparam logic [3:0] OP_LSR  = 4'b1000;
    localparam logic [3:0] OP_LSL  = 4'b1001;
    localparam logic [3:0] OP_ASR  = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1101;

    localparam int unsigned STW = 2;
    localparam logic [STW-1:0] ST_IDLE = 2'd0;
    localparam logic [STW-1:0] ST_BUSY = 2'd1;
    localparam logic [STW-1:0] ST_DONE = 2'd2;

    function automatic logic op_is_iter(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial datapath for MUL (shift-add), DIVU and REMU (restoring division).
// Finishes W cycles after i_start; o_done_c/o_result_c present the last step's outcome.
module alu_muldiv_iter
    import alu_mc_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [3:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_done_c,
    output logic [W-1:0] o_result_c
);

    localparam int unsigned CW = $clog2(W + 1);

    // r_acc: product accumulator / partial remainder
    // r_x:   multiplicand / dividend shifting into quotient
    // r_y:   multiplier / divisor
    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_op;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_x;
    logic [W-1:0]  r_y;

    logic [W:0]    w_rem_sh;
    logic [W+1:0]  w_trial;
    logic          w_borrow;
    logic [W-1:0]  w_acc_nxt;
    logic [W-1:0]  w_x_nxt;
    logic [W-1:0]  w_y_nxt;

    // One iteration of the selected algorithm
    always_comb begin
        w_rem_sh  = {r_acc, r_x[W-1]};
        w_trial   = {1'b0, w_rem_sh} - {2'b00, r_y};
        w_borrow  = w_trial[W+1];
        w_acc_nxt = r_acc;
        w_x_nxt   = r_x;
        w_y_nxt   = r_y;
        if (r_op == OP_MUL) begin
            if (r_y[0]) begin
                w_acc_nxt = r_acc + r_x;
            end
            w_x_nxt = r_x << 1;
            w_y_nxt = r_y >> 1;
        end else begin
            w_acc_nxt = w_borrow ? w_rem_sh[W-1:0] : w_trial[W-1:0];
            w_x_nxt   = {r_x[W-2:0], ~w_borrow};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_op   <= OP_MUL;
            r_acc  <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(W);
            r_op   <= i_op;
            r_acc  <= '0;
            r_x    <= i_a;
            r_y    <= i_b;
        end else if (r_busy) begin
            r_busy <= (r_cnt != CW'(1));
            r_cnt  <= r_cnt - CW'(1);
            r_acc  <= w_acc_nxt;
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
        end
    end

    assign o_done_c   = r_busy && (r_cnt == CW'(1));
    assign o_result_c = (r_op == OP_DIVU) ? w_x_nxt : w_acc_nxt;

endmodule

// File: rtl/alu_mc.sv
// Multicycle ALU: valid/ready handshake FSM, single-cycle operation mux and
// registered result/flags; MUL/DIVU/REMU are delegated to alu_muldiv_iter.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned SW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic [3:0]   alu_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         illegal
);

    logic [STW-1:0] r_state;
    logic [STW-1:0] w_state_nxt;
    logic           w_accept;
    logic           w_div0;
    logic           w_iter_start;
    logic [SW-1:0]  w_sh;
    logic [W-1:0]   w_sc_result;
    logic           w_sc_illegal;
    logic           w_iter_done_c;
    logic [W-1:0]   w_iter_result_c;
    logic [W-1:0]   w_result_nxt;
    logic           w_illegal_nxt;
    logic           w_load;

    // Single-cycle results; divide-by-zero is resolved here without iterating
    always_comb begin
        w_sh         = op2[SW-1:0];
        w_sc_result  = '0;
        w_sc_illegal = 1'b0;
        case (alu_op)
            OP_AND:  w_sc_result = op1 & op2;
            OP_OR:   w_sc_result = op1 | op2;
            OP_ADD:  w_sc_result = op1 + op2;
            OP_SUB:  w_sc_result = op1 - op2;
            OP_LESS: w_sc_result = {{(W-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_LSR:  w_sc_result = op1 >> w_sh;
            OP_LSL:  w_sc_result = op1 << w_sh;
            OP_ASR:  w_sc_result = $unsigned($signed(op1) >>> w_sh);
            OP_XOR:  w_sc_result = op1 ^ op2;
            OP_MUL:  w_sc_result = '0;
            OP_DIVU: w_sc_result = '1;
            OP_REMU: w_sc_result = op1;
            default: w_sc_illegal = 1'b1;
        endcase
    end

    assign w_accept     = in_valid && (r_state == ST_IDLE);
    assign w_div0       = (op2 == '0);
    assign w_iter_start = w_accept && op_is_iter(alu_op) && !((alu_op != OP_MUL) && w_div0);

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_result_nxt  = w_sc_result;
        w_illegal_nxt = w_sc_illegal;
        case (r_state)
            ST_IDLE: begin
                if (w_iter_start) begin
                    w_state_nxt = ST_BUSY;
                end else if (w_accept) begin
                    w_state_nxt = ST_DONE;
                    w_load      = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_iter_done_c) begin
                    w_state_nxt   = ST_DONE;
                    w_load        = 1'b1;
                    w_result_nxt  = w_iter_result_c;
                    w_illegal_nxt = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            in_ready  <= (w_state_nxt == ST_IDLE);
            out_valid <= (w_state_nxt == ST_DONE);
            if (w_load) begin
                result  <= w_result_nxt;
                zero    <= (w_result_nxt == '0);
                illegal <= w_illegal_nxt;
            end
        end
    end

    alu_muldiv_iter #(
        .W (W)
    ) u_muldiv (
        .clk        (clk),
        .rst_n      (rst),
        .i_start    (w_iter_start),
        .i_op       (alu_op),
        .i_a        (op1),
        .i_b        (op2),
        .o_done_c   (w_iter_done_c),
        .o_result_c (w_iter_result_c)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed and randomized ops at W=32 and W=8
// against an arithmetic reference model, plus backpressure and async reset.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, zero, illegal;
    logic [31:0] op1, op2, result;
    logic [3:0]  alu_op;

    logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8, zero_8, illegal_8;
    logic [7:0]  op1_8, op2_8, result_8;
    logic [3:0]  alu_op_8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_mc #(.W(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .alu_op(alu_op), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
    );

    alu_mc #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .op1(op1_8), .op2(op2_8), .alu_op(alu_op_8), .out_valid(out_valid_8),
        .out_ready(out_ready_8), .result(result_8), .zero(zero_8), .illegal(illegal_8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h6: return a - b;
            4'h7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h8: return a >> b[4:0];
            4'h9: return a << b[4:0];
            4'hA: return 32'(sa >>> b[4:0]);
            4'hD: return a ^ b;
            4'h3: return a * b;
            4'h4: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'h5: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [7:0] ref8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            4'h2: return a + b;
            4'h3: return a * b;
            4'h4: return (b == 0) ? 8'hFF : a / b;
            4'h5: return (b == 0) ? a : a % b;
            4'hA: return 8'(sa >>> b[2:0]);
            default: return 8'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic b_zero, input int w);
        if (op == 4'h3 || ((op == 4'h4 || op == 4'h5) && !b_zero)) return w + 1;
        return 1;
    endfunction

    function automatic logic ref_ill(input logic [3:0] op);
        return (op == 4'hB) || (op == 4'hC) || (op == 4'hE) || (op == 4'hF);
    endfunction

    // Issue one op on the W=32 instance, wait for the result, then drain it
    task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output logic il,
                         output int lat, output logic ir_busy);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        alu_op = op; op1 = a; op2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; op1 = $urandom; op2 = $urandom; alu_op = 4'($urandom);
        lat = 1; ir_busy = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ir_busy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) ir_busy = 1'b1;
        res = result; z = zero; il = illegal;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic z, output int lat);
        check("in_ready8_idle", 32'(in_ready_8), 32'd1);
        alu_op_8 = op; op1_8 = a; op2_8 = b; in_valid_8 = 1'b1;
        @(posedge clk); #1;
        in_valid_8 = 1'b0; op1_8 = 8'($urandom); op2_8 = 8'($urandom);
        lat = 1;
        while (!out_valid_8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result_8; z = zero_8;
        out_ready_8 = 1'b1;
        @(posedge clk); #1;
        out_ready_8 = 1'b0;
    endtask

    task automatic directed32(input string tag, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp, input logic exp_z,
                              input logic exp_il, input int exp_lat);
        logic [31:0] res;
        logic        z, il, irb;
        int          lat;
        run32(op, a, b, res, z, il, lat, irb);
        check({tag, "_res"}, res, exp);
        check({tag, "_zero"}, 32'(z), 32'(exp_z));
        check({tag, "_illegal"}, 32'(il), 32'(exp_il));
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_in_ready_busy"}, 32'(irb), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] res, a, b, e;
        logic [7:0]  res8, a8, b8, e8;
        logic [3:0]  op;
        logic        z, il, irb;
        int          lat;
        logic [3:0]  ops8 [5];
        ops8 = '{4'h3, 4'h4, 4'h5, 4'h2, 4'hA};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op1 = '0; op2 = '0; alu_op = '0;
        in_valid_8 = 1'b0; out_ready_8 = 1'b0; op1_8 = '0; op2_8 = '0; alu_op_8 = '0;
        #12;
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_valid8", 32'(out_valid_8), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        directed32("add_wrap",  4'h2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1);
        directed32("sub_zero",  4'h6, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1);
        directed32("less_neg",  4'h7, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
        directed32("asr",       4'hA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1);
        directed32("lsr",       4'h8, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 1);
        directed32("lsl",       4'h9, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 1);
        directed32("xor",       4'hD, 32'hF0F0_0000, 32'hFF00_00FF, 32'h0FF0_00FF, 1'b0, 1'b0, 1);
        directed32("mul",       4'h3, 32'h0001_0003, 32'd5, 32'h0005_000F, 1'b0, 1'b0, 33);
        directed32("mul_wrap",  4'h3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
        directed32("divu",      4'h4, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
        directed32("remu",      4'h5, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33);
        directed32("divu_by0",  4'h4, 32'd12345, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        directed32("remu_by0",  4'h5, 32'd9, 32'd0, 32'd9, 1'b0, 1'b0, 1);
        directed32("illegal",   4'hF, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 1);

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            e  = ref32(op, a, b);
            run32(op, a, b, res, z, il, lat, irb);
            check("rand_res", res, e);
            check("rand_zero", 32'(z), 32'(e == 32'd0));
            check("rand_illegal", 32'(il), 32'(ref_ill(op)));
            check("rand_latency", 32'(lat), 32'(ref_lat(op, b == 32'd0, 32)));
            check("rand_in_ready_busy", 32'(irb), 32'd0);
        end

        // Backpressure: the result must hold while the consumer stalls
        alu_op = 4'h3; op1 = 32'd6; op2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_result", result, 32'd42);
            check("bp_zero", 32'(zero), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a multiply
        directed32("pre_rst_add", 4'h2, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1);
        alu_op = 4'h3; op1 = 32'd3; op2 = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_zero", 32'(zero), 32'd0);
        #10 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        directed32("post_rst_add", 4'h2, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

        // Narrow instance
        run8(4'h3, 8'd15, 8'd17, res8, z, lat);
        check("w8_mul_res", 32'(res8), 32'hFF);
        check("w8_mul_latency", 32'(lat), 32'd9);
        run8(4'h4, 8'd200, 8'd3, res8, z, lat);
        check("w8_divu_res", 32'(res8), 32'd66);
        check("w8_divu_latency", 32'(lat), 32'd9);
        for (int i = 0; i < 40; i++) begin
            op = ops8[$urandom_range(0, 4)];
            a8 = 8'($urandom);
            b8 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
            e8 = ref8(op, a8, b8);
            run8(op, a8, b8, res8, z, lat);
            check("w8_rand_res", 32'(res8), 32'(e8));
            check("w8_rand_zero", 32'(z), 32'(e8 == 8'd0));
            check("w8_rand_latency", 32'(lat), 32'(ref_lat(op, b8 == 8'd0, 8)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
